bus_rr_ic: RTL

Parametrised shared-bus interconnect: NUM_M masters and NUM_S slaves over one shared address/data path, with registered round-robin arbitration and a bus-timeout watchdog. It replaces the fixed 4-master/8-slave fixed-priority bus in the SoC top level. The same arbiter, master mux, address decoder and slave mux functions are folded into one block, with fair grant rotation and recovery from unresponsive slaves added.

---
 rtl/bus_rr_ic.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/bus_rr_ic.sv
// Shared-bus interconnect: registered round-robin arbitration of NUM_M masters onto
// NUM_S slaves over one address/data path, with a watchdog that terminates stalled accesses.
module bus_rr_ic #(
  parameter int unsigned NUM_M   = 4,
  parameter int unsigned NUM_S   = 8,
  parameter int unsigned ADDR_W  = 30,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_M-1:0]         m_req_,
  output logic [NUM_M-1:0]         m_grnt_,
  input  logic [NUM_M*ADDR_W-1:0]  m_addr,
  input  logic [NUM_M-1:0]         m_as_,
  input  logic [NUM_M-1:0]         m_rw,
  input  logic [NUM_M*DATA_W-1:0]  m_wr_data,
  output logic [DATA_W-1:0]        m_rd_data,
  output logic                     m_rdy_,
  output logic                     m_err,
  output logic [ADDR_W-1:0]        s_addr,
  output logic                     s_as_,
  output logic                     s_rw,
  output logic [DATA_W-1:0]        s_wr_data,
  output logic [NUM_S-1:0]         s_cs_,
  input  logic [NUM_S*DATA_W-1:0]  s_rd_data,
  input  logic [NUM_S-1:0]         s_rdy_,
  output logic [7:0]               to_count
);

  localparam int unsigned MW = (NUM_M > 1) ? $clog2(NUM_M) : 1;
  localparam int unsigned SW = $clog2(NUM_S);
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [MW-1:0]     r_owner;
  logic [MW-1:0]     r_last;
  logic              r_busy;
  logic [CW-1:0]     r_wcnt;
  logic [7:0]        r_to_count;

  logic [MW-1:0]     w_next;
  logic [MW-1:0]     w_idx;
  logic              w_found;
  logic              w_keep;
  logic [SW-1:0]     w_sel;
  logic              w_qual;
  logic              w_raw_rdy;
  logic              w_hit;

  logic [ADDR_W-1:0] w_addr_arr  [NUM_M];
  logic [DATA_W-1:0] w_wdata_arr [NUM_M];
  logic [DATA_W-1:0] w_rdata_arr [NUM_S];

  // Unpack flat sliced buses into indexable arrays
  always_comb begin
    for (int i = 0; i < int'(NUM_M); i++) begin
      w_addr_arr[i]  = m_addr[i*ADDR_W +: ADDR_W];
      w_wdata_arr[i] = m_wr_data[i*DATA_W +: DATA_W];
    end
    for (int j = 0; j < int'(NUM_S); j++) begin
      w_rdata_arr[j] = s_rd_data[j*DATA_W +: DATA_W];
    end
  end

  // Round-robin scan starting one past the last granted master
  always_comb begin
    w_found = 1'b0;
    w_next  = r_owner;
    w_idx   = '0;
    for (int k = 1; k <= int'(NUM_M); k++) begin
      w_idx = MW'((int'(r_last) + k) % int'(NUM_M));
      if (!w_found && !m_req_[w_idx]) begin
        w_found = 1'b1;
        w_next  = w_idx;
      end
    end
  end

  assign w_keep = r_busy && !m_req_[r_owner];

  // Master mux driven from the registered owner
  always_comb begin
    s_addr    = '0;
    s_as_     = 1'b1;
    s_rw      = 1'b1;
    s_wr_data = '0;
    if (r_busy) begin
      s_addr    = w_addr_arr[r_owner];
      s_as_     = m_as_[r_owner];
      s_rw      = m_rw[r_owner];
      s_wr_data = w_wdata_arr[r_owner];
    end
  end

  assign w_sel     = s_addr[ADDR_W-1 -: SW];
  assign w_qual    = r_busy && !s_as_;
  assign w_raw_rdy = w_qual ? s_rdy_[w_sel] : 1'b1;
  // A real ready in the hit cycle wins over the timeout
  assign w_hit     = w_qual && w_raw_rdy && (r_wcnt == CW'(TIMEOUT));

  assign m_rdy_    = w_raw_rdy & ~w_hit;
  assign m_err     = w_hit;
  assign m_rd_data = (w_qual && !w_hit) ? w_rdata_arr[w_sel] : '0;
  assign to_count  = r_to_count;

  always_comb begin
    for (int i = 0; i < int'(NUM_M); i++) begin
      m_grnt_[i] = !(r_busy && (r_owner == MW'(i)));
    end
    for (int j = 0; j < int'(NUM_S); j++) begin
      s_cs_[j] = !(r_busy && (w_sel == SW'(j)));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy     <= 1'b0;
      r_owner    <= '0;
      r_last     <= MW'(NUM_M - 1);
      r_wcnt     <= '0;
      r_to_count <= '0;
    end else begin
      if (!w_keep) begin
        r_busy <= w_found;
        if (w_found) begin
          r_owner <= w_next;
          r_last  <= w_next;
        end
      end
      if (!w_qual || !w_raw_rdy || w_hit) begin
        r_wcnt <= '0;
      end else begin
        r_wcnt <= r_wcnt + CW'(1);
      end
      if (w_hit && (r_to_count != 8'hFF)) begin
        r_to_count <= r_to_count + 8'd1;
      end
    end
  end

endmodule
